// File: rtl/pipeline_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline stall/flush controller.
//   state_t  : controller FSM state (RUN / MEM_WAIT / ERR)
//   ctrl_t   : bundle of the five pipeline enable/flush controls
//   REG_ZERO : architectural zero register index (never a real hazard)
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic is_control;
        logic if_id_flush;
        logic pipe_hold;
    } ctrl_t;

    // Normal flow: everything advances, nothing cleared.
    localparam ctrl_t CTRL_RUN    = ctrl_t'(5'b11100);
    // Taken branch: advance, but clear the wrong-path fetch in IF/ID.
    localparam ctrl_t CTRL_FLUSH  = ctrl_t'(5'b11110);
    // Load-use: freeze PC and IF/ID, push a bubble into ID/EX.
    localparam ctrl_t CTRL_BUBBLE = ctrl_t'(5'b00000);
    // Full freeze of front and back end (memory wait / error lock).
    localparam ctrl_t CTRL_HOLD   = ctrl_t'(5'b00101);

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl_if
// Groups the hazard inputs and the stall/flush outputs of the controller.
//   master : pipeline side (drives ID/EX hazard info and memory handshake)
//   slave  : controller side (drives enables, flush, hold, error, stats)
// Handshake: mem_req is high for every cycle MEM accesses data memory;
// mem_ack is high exactly in the cycle the access completes (may coincide
// with the first mem_req cycle for a zero-wait access). The controller
// holds the pipe on every cycle mem_req is outstanding without mem_ack.
// ---------------------------------------------------------------------------
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       IF_ID_Rs_addr;
    logic [4:0]       IF_ID_Rt_addr;
    logic [4:0]       ID_EX_Rt_addr;
    logic             ID_EX_MemRead;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ack;

    logic             PC_Write;
    logic             IF_ID_write;
    logic             isControl;
    logic             IF_ID_flush;
    logic             pipe_hold;
    logic             mem_err;
    logic [CNT_W-1:0] load_stall_cnt;
    logic [CNT_W-1:0] mem_stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output IF_ID_Rs_addr, IF_ID_Rt_addr, ID_EX_Rt_addr, ID_EX_MemRead,
               branch_taken, mem_req, mem_ack,
        input  PC_Write, IF_ID_write, isControl, IF_ID_flush, pipe_hold,
               mem_err, load_stall_cnt, mem_stall_cnt, flush_cnt
    );

    modport slave (
        input  IF_ID_Rs_addr, IF_ID_Rt_addr, ID_EX_Rt_addr, ID_EX_MemRead,
               branch_taken, mem_req, mem_ack,
        output PC_Write, IF_ID_write, isControl, IF_ID_flush, pipe_hold,
               mem_err, load_stall_cnt, mem_stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard comparator, shareable with forwarding.
//   i_mem_read : instruction in EX is a load
//   i_ex_rt    : load destination register in EX
//   i_id_rs    : rs of the instruction in ID
//   i_id_rt    : rt of the instruction in ID
//   o_load_use : ID instruction consumes the pending load result
// ---------------------------------------------------------------------------
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       i_mem_read,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    output logic       o_load_use
);
    // A load into the zero register produces nothing to wait for.
    assign o_load_use = i_mem_read && (i_ex_rt != REG_ZERO) &&
                        ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
// Prioritised stall/flush sequencer for the 5-stage pipeline: memory wait
// (highest), load-use bubble, taken-branch flush. A watchdog on the memory
// wait locks the pipe in ERR until reset.
// Parameters: MEM_TIMEOUT (1..255) max MEM_WAIT cycles without ack,
//             CNT_W statistics counter width.
// Ports: clk, rst (synchronous, active high), bus (slave modport of
//        pipeline_stall_ctrl_if), o_dbg_state (current FSM state).
// Build option: STALL_STATS_EN enables the saturating statistics counters;
//               without it the counter outputs are constant zero.
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_stall_ctrl_if.slave  bus,
    output state_t                o_dbg_state
);
    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;
    logic              w_load_use;
    logic              w_mem_stall;
    ctrl_t             w_run_ctrl;
    ctrl_t             w_ctrl;

    load_use_detect u_load_use (
        .i_mem_read (bus.ID_EX_MemRead),
        .i_ex_rt    (bus.ID_EX_Rt_addr),
        .i_id_rs    (bus.IF_ID_Rs_addr),
        .i_id_rt    (bus.IF_ID_Rt_addr),
        .o_load_use (w_load_use)
    );

    assign w_mem_stall = bus.mem_req && !bus.mem_ack;

    // RUN decision without the memory term; also used in the MEM_WAIT ack
    // cycle so a hazard held in ID during the wait is acted on immediately.
    // A branch seen together with a load-use is dropped: it stays in ID.
    always_comb begin
        w_run_ctrl = CTRL_RUN;
        if (w_load_use) begin
            w_run_ctrl = CTRL_BUBBLE;
        end else if (bus.branch_taken) begin
            w_run_ctrl = CTRL_FLUSH;
        end
    end

    always_comb begin
        w_ctrl = CTRL_RUN;
        if (!rst) begin
            case (r_state)
                RUN:      w_ctrl = w_mem_stall  ? CTRL_HOLD  : w_run_ctrl;
                MEM_WAIT: w_ctrl = bus.mem_ack  ? w_run_ctrl : CTRL_HOLD;
                default:  w_ctrl = CTRL_HOLD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_wait_cnt <= '0;
                    if (w_mem_stall) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    // The ack wins over a simultaneous timeout.
                    if (bus.mem_ack) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WAIT_MAX) begin
                        r_state    <= ERR;
                        r_wait_cnt <= '0;
                        r_mem_err  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ERR: begin
                    r_wait_cnt <= '0;
                    r_mem_err  <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: lock up rather than run blind.
                    r_state    <= ERR;
                    r_wait_cnt <= '0;
                    r_mem_err  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.PC_Write    = w_ctrl.pc_write;
    assign bus.IF_ID_write = w_ctrl.if_id_write;
    assign bus.isControl   = w_ctrl.is_control;
    assign bus.IF_ID_flush = w_ctrl.if_id_flush;
    assign bus.pipe_hold   = w_ctrl.pipe_hold;
    assign bus.mem_err     = r_mem_err;
    assign o_dbg_state     = r_state;

`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] r_load_cnt;
    logic [CNT_W-1:0] r_mem_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_cnt  <= '0;
            r_mem_cnt   <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_ctrl.is_control && (r_load_cnt != '1)) begin
                r_load_cnt <= r_load_cnt + CNT_W'(1);
            end
            if (w_ctrl.pipe_hold && (r_state != ERR) && (r_mem_cnt != '1)) begin
                r_mem_cnt <= r_mem_cnt + CNT_W'(1);
            end
            if (w_ctrl.if_id_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.load_stall_cnt = r_load_cnt;
    assign bus.mem_stall_cnt  = r_mem_cnt;
    assign bus.flush_cnt      = r_flush_cnt;
`else
    assign bus.load_stall_cnt = '0;
    assign bus.mem_stall_cnt  = '0;
    assign bus.flush_cnt      = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
// Directed scenarios plus randomized traffic against a cycle-level
// reference model of the stall/flush rules. Output vector order:
// {PC_Write, IF_ID_write, isControl, IF_ID_flush, pipe_hold, mem_err}.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  localparam logic [5:0] E_RUN   = 6'b111000;
  localparam logic [5:0] E_FLUSH = 6'b111100;
  localparam logic [5:0] E_BUB   = 6'b000000;
  localparam logic [5:0] E_HOLD  = 6'b001010;
  localparam logic [5:0] E_ERR   = 6'b001011;

  // ---------------- clock / reset / DUT ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;

  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int         errors = 0;
  int         checks = 0;
  logic [5:0] exp_q[$];
  int         m_wait = 0;   // cycles spent waiting on memory, 0 = not waiting
  bit         m_err  = 0;
  int         m_load = 0;
  int         m_mem  = 0;
  int         m_flush = 0;

  function automatic logic [5:0] dut_outs();
    return {bus.PC_Write, bus.IF_ID_write, bus.isControl, bus.IF_ID_flush,
            bus.pipe_hold, bus.mem_err};
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt(int c);
    logic [CNT_W-1:0] r;
    r = (c >= CNT_MAX) ? CNT_W'(CNT_MAX) : c[CNT_W-1:0];
`ifndef STALL_STATS_EN
    r = '0;
`endif
    return r;
  endfunction

  // Expected outputs for the present inputs, from the priority rules.
  function automatic logic [5:0] model_expect();
    logic lu;
    lu = bus.ID_EX_MemRead && (bus.ID_EX_Rt_addr != 5'd0) &&
         (bus.ID_EX_Rt_addr == bus.IF_ID_Rs_addr || bus.ID_EX_Rt_addr == bus.IF_ID_Rt_addr);
    if (rst)                                   return {5'b11100, m_err};
    if (m_err)                                 return E_ERR;
    if (!bus.mem_ack && (m_wait > 0 || bus.mem_req)) return E_HOLD;
    if (lu)                                    return E_BUB;
    if (bus.branch_taken)                      return E_FLUSH;
    return E_RUN;
  endfunction

  task automatic model_advance();
    logic [5:0] e;
    e = model_expect();
    if (rst) begin
      m_wait = 0; m_err = 0; m_load = 0; m_mem = 0; m_flush = 0;
      return;
    end
    if (!e[3])          m_load++;
    if (e[1] && !m_err) m_mem++;
    if (e[2])           m_flush++;
    if (m_err) begin
    end else if (m_wait == 0) begin
      if (bus.mem_req && !bus.mem_ack) m_wait = 1;
    end else if (bus.mem_ack) begin
      m_wait = 0;
    end else if (m_wait == MEM_TIMEOUT) begin
      m_err = 1; m_wait = 0;
    end else begin
      m_wait++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ex_rt,
                        input logic rd, input logic br, input logic req, input logic ack);
    bus.IF_ID_Rs_addr = rs;
    bus.IF_ID_Rt_addr = rt;
    bus.ID_EX_Rt_addr = ex_rt;
    bus.ID_EX_MemRead = rd;
    bus.branch_taken  = br;
    bus.mem_req       = req;
    bus.mem_ack       = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    logic [5:0] got;
    rst = 1'b1;
    set_in(5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    got = dut_outs();
    checks++; if (got !== E_RUN) begin errors++; $display("FAIL reset_outs got=%b exp=%b", got, E_RUN); end
    checks++; if (dbg_state !== RUN) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, RUN); end
    checks++; if ({bus.load_stall_cnt, bus.mem_stall_cnt, bus.flush_cnt} !== '0) begin
      errors++; $display("FAIL reset_cnt got=%h/%h/%h exp=0", bus.load_stall_cnt, bus.mem_stall_cnt, bus.flush_cnt);
    end
    tick();
    rst = 1'b0;
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    got = dut_outs();
    checks++; if (got !== E_RUN) begin errors++; $display("FAIL idle_outs got=%b exp=%b", got, E_RUN); end
    tick();
  endtask

  task automatic test_load_use();
    logic [5:0] got;
    int base;
    base = m_load;
    set_in(5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); got = dut_outs();
    checks++; if (got !== E_BUB) begin errors++; $display("FAIL lu_rs_bubble got=%b exp=%b", got, E_BUB); end
    tick();
    set_in(5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); got = dut_outs();
    checks++; if (got !== E_RUN) begin errors++; $display("FAIL lu_after got=%b exp=%b", got, E_RUN); end
    checks++; if (bus.load_stall_cnt !== exp_cnt(base + 1)) begin
      errors++; $display("FAIL lu_cnt got=%0d exp=%0d", bus.load_stall_cnt, exp_cnt(base + 1));
    end
    tick();
    set_in(5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); got = dut_outs();
    checks++; if (got !== E_BUB) begin errors++; $display("FAIL lu_rt_bubble got=%b exp=%b", got, E_BUB); end
    tick();
    set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); got = dut_outs();
    checks++; if (got !== E_RUN) begin errors++; $display("FAIL lu_reg_zero got=%b exp=%b", got, E_RUN); end
    tick();
  endtask

  task automatic test_mem_wait();
    logic [5:0] got;
    int base;
    base = m_mem;
    for (int c = 0; c < 3; c++) begin
      set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk); got = dut_outs();
      checks++; if (got !== E_HOLD) begin errors++; $display("FAIL mem_hold[%0d] got=%b exp=%b", c, got, E_HOLD); end
      tick();
    end
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk); got = dut_outs();
    checks++; if (got !== E_RUN) begin errors++; $display("FAIL mem_ack got=%b exp=%b", got, E_RUN); end
    tick();
    checks++; if (bus.mem_stall_cnt !== exp_cnt(base + 3)) begin
      errors++; $display("FAIL mem_cnt got=%0d exp=%0d", bus.mem_stall_cnt, exp_cnt(base + 3));
    end
    // zero-wait access: no stall
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk); got = dut_outs();
    checks++; if (got !== E_RUN) begin errors++; $display("FAIL mem_zero_wait got=%b exp=%b", got, E_RUN); end
    tick();
    checks++; if (dbg_state !== RUN) begin errors++; $display("FAIL mem_zero_state got=%0d exp=%0d", dbg_state, RUN); end
  endtask

  task automatic test_branch_in_wait();
    logic [5:0] got;
    for (int c = 0; c < 2; c++) begin
      set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk); got = dut_outs();
      checks++; if (got !== E_HOLD) begin errors++; $display("FAIL br_wait_hold[%0d] got=%b exp=%b", c, got, E_HOLD); end
      tick();
    end
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk); got = dut_outs();
    checks++; if (got !== E_FLUSH) begin errors++; $display("FAIL br_wait_ack got=%b exp=%b", got, E_FLUSH); end
    tick();
    // load-use held through a wait is bubbled in the ack cycle
    set_in(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk); got = dut_outs();
    checks++; if (got !== E_BUB) begin errors++; $display("FAIL lu_wait_ack got=%b exp=%b", got, E_BUB); end
    tick();
  endtask

  task automatic test_lu_and_branch();
    logic [5:0] got;
    set_in(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); got = dut_outs();
    checks++; if (got !== E_BUB) begin errors++; $display("FAIL lu_br got=%b exp=%b", got, E_BUB); end
    tick();
    set_in(5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); got = dut_outs();
    checks++; if (got !== E_FLUSH) begin errors++; $display("FAIL br_only got=%b exp=%b", got, E_FLUSH); end
    tick();
  endtask

  task automatic test_ack_at_timeout();
    logic [5:0] got;
    for (int c = 0; c < MEM_TIMEOUT; c++) begin
      set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk); got = dut_outs();
    checks++; if (got !== E_RUN) begin errors++; $display("FAIL ack_at_to got=%b exp=%b", got, E_RUN); end
    tick();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (dbg_state !== RUN || bus.mem_err !== 1'b0) begin
      errors++; $display("FAIL ack_at_to_state got=%0d/%b exp=%0d/0", dbg_state, bus.mem_err, RUN);
    end
    tick();
  endtask

  task automatic test_timeout();
    logic [5:0] got;
    for (int c = 1; c <= MEM_TIMEOUT + 1; c++) begin
      set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk); got = dut_outs();
      checks++; if (got !== E_HOLD) begin errors++; $display("FAIL to_hold[%0d] got=%b exp=%b", c, got, E_HOLD); end
      tick();
    end
    @(negedge clk); got = dut_outs();
    checks++; if (got !== E_ERR) begin errors++; $display("FAIL to_err got=%b exp=%b", got, E_ERR); end
    tick();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk); got = dut_outs();
    checks++; if (got !== E_ERR || dbg_state !== ERR) begin
      errors++; $display("FAIL to_err_held got=%b/%0d exp=%b/%0d", got, dbg_state, E_ERR, ERR);
    end
    tick();
    rst = 1'b1;
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); got = dut_outs();
    checks++; if (got !== 6'b111001) begin errors++; $display("FAIL to_rst_outs got=%b exp=%b", got, 6'b111001); end
    tick();
    rst = 1'b0;
    @(negedge clk); got = dut_outs();
    checks++; if (got !== E_RUN || dbg_state !== RUN) begin
      errors++; $display("FAIL to_rst_clear got=%b/%0d exp=%b/%0d", got, dbg_state, E_RUN, RUN);
    end
    checks++; if (bus.mem_stall_cnt !== '0) begin errors++; $display("FAIL to_rst_cnt got=%0d exp=0", bus.mem_stall_cnt); end
    tick();
  endtask

  task automatic test_random();
    logic [5:0] got;
    logic [5:0] exp;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0));
      exp_q.push_back(model_expect());
      @(negedge clk);
      got = dut_outs();
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL rand_outs[%0d] got=%b exp=%b", n, got, exp); end
      checks++; if (bus.load_stall_cnt !== exp_cnt(m_load) || bus.mem_stall_cnt !== exp_cnt(m_mem) ||
                    bus.flush_cnt !== exp_cnt(m_flush)) begin
        errors++;
        $display("FAIL rand_cnt[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, bus.load_stall_cnt,
                 bus.mem_stall_cnt, bus.flush_cnt, exp_cnt(m_load), exp_cnt(m_mem), exp_cnt(m_flush));
      end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < CNT_MAX + 10; n++) tick();
    @(negedge clk);
    checks++; if (bus.flush_cnt !== exp_cnt(CNT_MAX + 10)) begin
      errors++; $display("FAIL flush_sat got=%0d exp=%0d", bus.flush_cnt, exp_cnt(CNT_MAX + 10));
    end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch_in_wait();
    test_lu_and_branch();
    test_ack_at_timeout();
    test_timeout();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
